// File: rtl/apb_cordic_slave.sv
// rtl/apb_cordic_slave.sv - APB-mapped iterative rotation-mode CORDIC returning Q1.14 cos/sin
// One CORDIC iteration per HCLK; RESULT reads stall with PREADY low until the run finishes.
module apb_cordic_slave #(
  parameter int N_ITER = 14,
  parameter int IW     = 18
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        IRQ
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic signed [IW-1:0] K_INIT  = IW'(9949);
  localparam logic signed [IW-1:0] SAT_MAX = IW'(32767);
  localparam logic signed [IW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [4:0]           LAST_IT = 5'(N_ITER - 1);

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ie;
  logic [15:0]           r_angle;
  logic signed [IW-1:0]  r_x;
  logic signed [IW-1:0]  r_y;
  logic [15:0]           r_z;
  logic [4:0]            r_cnt;
  logic [15:0]           r_cos;
  logic [15:0]           r_sin;

  logic [1:0]            w_addr;
  logic                  w_stall;
  logic                  w_wr;
  logic                  w_start;
  logic signed [IW-1:0]  w_x0;
  logic signed [IW-1:0]  w_y0;
  logic [15:0]           w_z0;
  logic signed [IW-1:0]  w_xs;
  logic signed [IW-1:0]  w_ys;
  logic                  w_pos;
  logic [15:0]           w_atan;
  logic signed [IW-1:0]  w_xn;
  logic signed [IW-1:0]  w_yn;
  logic [15:0]           w_zn;
  logic                  w_unused;

  function automatic logic [15:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0:    atan_lut = 16'd8192;
      5'd1:    atan_lut = 16'd4836;
      5'd2:    atan_lut = 16'd2555;
      5'd3:    atan_lut = 16'd1297;
      5'd4:    atan_lut = 16'd651;
      5'd5:    atan_lut = 16'd326;
      5'd6:    atan_lut = 16'd163;
      5'd7:    atan_lut = 16'd81;
      5'd8:    atan_lut = 16'd41;
      5'd9:    atan_lut = 16'd20;
      5'd10:   atan_lut = 16'd10;
      5'd11:   atan_lut = 16'd5;
      5'd12:   atan_lut = 16'd3;
      5'd13:   atan_lut = 16'd1;
      5'd14:   atan_lut = 16'd1;
      default: atan_lut = 16'd0;
    endcase
  endfunction

  function automatic logic [15:0] sat16(input logic signed [IW-1:0] v);
    if (v > SAT_MAX)      sat16 = 16'h7FFF;
    else if (v < SAT_MIN) sat16 = 16'h8000;
    else                  sat16 = v[15:0];
  endfunction

  assign w_addr   = PADDR[3:2];
  assign w_stall  = PSEL & PENABLE & ~PWRITE & (w_addr == 2'd3) & r_busy;
  assign PREADY   = ~w_stall;
  assign w_wr     = PSEL & PENABLE & PWRITE & PREADY;
  assign w_start  = w_wr & (w_addr == 2'd0) & PWDATA[0] & ~r_busy;
  assign IRQ      = r_done & r_ie;
  assign w_unused = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:16]};

  always_comb begin
    PRDATA = 32'h0;
    if (PSEL && !PWRITE) begin
      case (w_addr)
        2'd0:    PRDATA = {30'h0, r_ie, 1'b0};
        2'd1:    PRDATA = {16'h0, r_angle};
        2'd2:    PRDATA = {30'h0, r_done, r_busy};
        default: PRDATA = {r_sin, r_cos};
      endcase
    end
  end

  // Fold the angle into +-pi/2 so the CORDIC stays inside its convergence range.
  always_comb begin
    w_x0 = K_INIT;
    w_y0 = '0;
    w_z0 = r_angle;
    case (r_angle[15:14])
      2'b01: begin
        w_x0 = '0;
        w_y0 = K_INIT;
        w_z0 = r_angle - 16'h4000;
      end
      2'b10: begin
        w_x0 = '0;
        w_y0 = -K_INIT;
        w_z0 = r_angle + 16'h4000;
      end
      default: ;
    endcase
  end

  assign w_xs   = r_x >>> r_cnt;
  assign w_ys   = r_y >>> r_cnt;
  assign w_pos  = ~r_z[15];
  assign w_atan = atan_lut(r_cnt);
  assign w_xn   = w_pos ? (r_x - w_ys) : (r_x + w_ys);
  assign w_yn   = w_pos ? (r_y + w_xs) : (r_y - w_xs);
  assign w_zn   = w_pos ? (r_z - w_atan) : (r_z + w_atan);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ie    <= 1'b0;
      r_angle <= 16'h0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= 16'h0;
      r_cnt   <= 5'd0;
      r_cos   <= 16'h0;
      r_sin   <= 16'h0;
    end else begin
      // IE follows every accepted CTRL write, even while a run is in progress.
      if (w_wr && w_addr == 2'd0) r_ie <= PWDATA[1];
      if (w_wr && w_addr == 2'd1 && !r_busy) r_angle <= PWDATA[15:0];
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_x     <= w_x0;
            r_y     <= w_y0;
            r_z     <= w_z0;
            r_cnt   <= 5'd0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_x   <= w_xn;
          r_y   <= w_yn;
          r_z   <= w_zn;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == LAST_IT) begin
            r_cos   <= sat16(w_xn);
            r_sin   <= sat16(w_yn);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cordic_slave.sv
// tb/tb_apb_cordic_slave.sv - randomized self-checking bench for apb_cordic_slave
// Expected cos/sin come from real-valued trigonometry; timing from the register-level rules.
module tb_apb_cordic_slave;

  localparam int N = 14;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        IRQ;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc++;

  apb_cordic_slave #(.N_ITER(N), .IW(18)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .IRQ     (IRQ)
  );

  task automatic check(input string tag, input int act, input int exp, input int tol);
    n_chk++;
    if (act > exp + tol || act < exp - tol) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, act, exp, tol);
    end
  endtask

  function automatic int ref_trig(input logic [15:0] a, input bit want_sin);
    real r;
    real v;
    r = real'(a) * 3.141592653589793 / 32768.0;
    v = want_sin ? $sin(r) : $cos(r);
    return $rtoi($floor(v * 16384.0 + 0.5));
  endfunction

  // Full setup+access transfer; returns read data and the number of wait states seen.
  task automatic apb_xfer(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int waits);
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = {28'h0, a}; PWDATA = wd;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    waits = 0;
    #1;
    while (!PREADY && waits < 200) begin
      @(posedge HCLK); #2;
      waits++;
    end
    rd = PRDATA;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] rd;
    int w;
    apb_xfer(1'b1, a, d, rd, w);
  endtask

  task automatic apb_rd(input logic [3:0] a, output logic [31:0] rd, output int w);
    apb_xfer(1'b0, a, 32'h0, rd, w);
  endtask

  task automatic wait_irq(output int n);
    n = 0;
    while (!IRQ && n < 200) begin
      @(posedge HCLK); #1;
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] rd,
                              input logic [15:0] a, input int tol);
    logic signed [15:0] c;
    logic signed [15:0] s;
    c = rd[15:0];
    s = rd[31:16];
    check({tag, "_cos"}, int'(c), ref_trig(a, 1'b0), tol);
    check({tag, "_sin"}, int'(s), ref_trig(a, 1'b1), tol);
  endtask

  // START with IE=0 then read RESULT at once; the read must stall until DONE.
  task automatic run_angle(input string tag, input logic [15:0] a, input int tol);
    logic [31:0] rd;
    int w;
    apb_wr(4'h4, {16'h0, a});
    apb_wr(4'h0, 32'h1);
    apb_rd(4'hC, rd, w);
    check({tag, "_waits"}, w, N - 2, 0);
    check_result(tag, rd, a, tol);
  endtask

  initial begin
    logic [31:0] rd;
    int w;
    int n;
    int c0;
    logic [15:0] a;

    HRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 32'h0; PWDATA = 32'h0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;

    #1;
    check("rst_pready", int'(PREADY), 1, 0);
    check("rst_irq", int'(IRQ), 0, 0);
    check("rst_prdata", int'(PRDATA), 0, 0);
    for (int r = 0; r < 4; r++) begin
      apb_rd(4'(r * 4), rd, w);
      check("rst_reg", int'(rd), 0, 0);
      check("rst_reg_waits", w, 0, 0);
    end

    // Angle 0 with IE: latency measured via IRQ rising on the DONE edge.
    apb_wr(4'h4, 32'h0);
    apb_wr(4'h0, 32'h3);
    c0 = cyc;
    apb_rd(4'h8, rd, w);
    check("status_busy", int'(rd), 1, 0);
    check("status_no_stall", w, 0, 0);
    wait_irq(n);
    check("irq_latency", cyc - c0, N, 0);
    apb_rd(4'h8, rd, w);
    check("status_done", int'(rd), 2, 0);
    apb_rd(4'hC, rd, w);
    check("a0_waits", w, 0, 0);
    check_result("a0", rd, 16'h0000, 8);
    apb_rd(4'h0, rd, w);
    check("ctrl_read", int'(rd), 2, 0);
    check("irq_level", int'(IRQ), 1, 0);
    apb_wr(4'h0, 32'h0);
    #1;
    check("irq_ie_off", int'(IRQ), 0, 0);
    apb_rd(4'h8, rd, w);
    check("done_sticky", int'(rd), 2, 0);

    run_angle("a2000", 16'h2000, 8);
    run_angle("a4000", 16'h4000, 8);
    run_angle("a8000", 16'h8000, 8);
    run_angle("aA000", 16'hA000, 8);

    // Mid-run ANGLE write and second START must both be ignored.
    apb_wr(4'h4, 32'h1000);
    apb_wr(4'h0, 32'h3);
    c0 = cyc;
    apb_wr(4'h4, 32'h7000);
    apb_wr(4'h0, 32'h3);
    wait_irq(n);
    check("restart_latency", cyc - c0, N, 0);
    apb_rd(4'h4, rd, w);
    check("angle_kept", int'(rd), 32'h1000, 0);
    apb_rd(4'hC, rd, w);
    check_result("a1000", rd, 16'h1000, 8);

    // Reset pulse at iteration 5 aborts the run and clears everything.
    apb_wr(4'h4, 32'h3000);
    apb_wr(4'h0, 32'h1);
    repeat (5) @(posedge HCLK);
    #1 HRESETn = 1'b0;
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    apb_rd(4'h8, rd, w);
    check("abort_status", int'(rd), 0, 0);
    apb_rd(4'hC, rd, w);
    check("abort_result", int'(rd), 0, 0);
    apb_rd(4'h4, rd, w);
    check("abort_angle", int'(rd), 0, 0);
    run_angle("post_rst", 16'hE000, 8);

    for (int k = 0; k < 12; k++) begin
      a = 16'($urandom);
      run_angle("rand", a, 12);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
